// File: rtl/key_gen_pkg.sv
// key_gen_pkg: shared state encoding, released level and counter sizing for the key press generator.
package key_gen_pkg;
  typedef enum logic [2:0] {IDLE, BNC_DN, HOLD, BNC_UP, GAP} key_state_e;
  localparam logic KEY_RELEASED = 1'b1;
  function automatic int cnt_width(input int hold, input int gap, input int bounce);
    int m;
    m = (hold > gap) ? hold : gap;
    m = (m > bounce) ? m : bounce;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/key_press_chan.sv
// key_press_chan: one emulated push-button channel with bounce, hold, gap and a 1-deep pending slot.
module key_press_chan
  import key_gen_pkg::*;
#(
  parameter int HOLD_CYCLES    = 1000000,
  parameter int GAP_CYCLES     = 500000,
  parameter int BOUNCE_CYCLES  = 5000,
  parameter int BOUNCE_TOGGLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  output logic o_key_n,
  output logic o_busy,
  output logic o_drop
);
  localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES, BOUNCE_CYCLES);
  localparam int PW = (BOUNCE_TOGGLES == 0) ? 1 : $clog2(2 * BOUNCE_TOGGLES + 1);
  localparam bit HAS_BNC = BOUNCE_TOGGLES > 0;
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] BNC_LD = CW'(BOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PH_LAST = PW'(HAS_BNC ? 2 * BOUNCE_TOGGLES - 1 : 0);
  // With clean edges the bounce states are bypassed entirely.
  localparam key_state_e S_PRESS = HAS_BNC ? BNC_DN : HOLD;
  localparam key_state_e S_REL = HAS_BNC ? BNC_UP : GAP;
  localparam logic [CW-1:0] PRESS_LD = HAS_BNC ? BNC_LD : HOLD_LD;
  localparam logic [CW-1:0] REL_LD = HAS_BNC ? BNC_LD : GAP_LD;

  key_state_e r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [PW-1:0] r_phase, w_phase;
  logic r_pend, w_pend, r_key_n, w_key_n, r_busy, r_drop, w_drop;
  logic w_last, w_gap_end, w_active;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_phase <= '0;
      r_pend  <= 1'b0;
      r_key_n <= KEY_RELEASED;
      r_busy  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_phase <= w_phase;
      r_pend  <= w_pend;
      r_key_n <= w_key_n;
      r_busy  <= w_state != IDLE;
      r_drop  <= w_drop;
    end

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_phase   = r_phase;
    w_key_n   = r_key_n;
    w_last    = r_cnt == '0;
    w_active  = r_state != IDLE;
    w_gap_end = (r_state == GAP) && w_last;
    case (r_state)
      IDLE:
        if (i_req) begin
          w_state = S_PRESS;
          w_cnt   = PRESS_LD;
          w_phase = '0;
          w_key_n = ~KEY_RELEASED;
        end
      BNC_DN:
        if (!w_last) w_cnt = r_cnt - 1'b1;
        else if (r_phase == PH_LAST) begin
          w_state = HOLD;
          w_cnt   = HOLD_LD;
          w_key_n = ~KEY_RELEASED;
        end else begin
          w_phase = r_phase + 1'b1;
          w_cnt   = BNC_LD;
          w_key_n = ~r_phase[0];
        end
      HOLD:
        if (!w_last) w_cnt = r_cnt - 1'b1;
        else begin
          w_state = S_REL;
          w_cnt   = REL_LD;
          w_phase = '0;
          w_key_n = KEY_RELEASED;
        end
      BNC_UP:
        if (!w_last) w_cnt = r_cnt - 1'b1;
        else if (r_phase == PH_LAST) begin
          w_state = GAP;
          w_cnt   = GAP_LD;
          w_key_n = KEY_RELEASED;
        end else begin
          w_phase = r_phase + 1'b1;
          w_cnt   = BNC_LD;
          w_key_n = r_phase[0];
        end
      GAP:
        if (!w_last) w_cnt = r_cnt - 1'b1;
        else if (r_pend || i_req) begin
          w_state = S_PRESS;
          w_cnt   = PRESS_LD;
          w_phase = '0;
          w_key_n = ~KEY_RELEASED;
        end else w_state = IDLE;
      default: begin
        w_state = IDLE;
        w_key_n = KEY_RELEASED;
      end
    endcase
    // At gap end the slot is consumed; a request arriving that same cycle refills it.
    w_pend = w_gap_end ? (r_pend & i_req) : (r_pend | (i_req & w_active));
    w_drop = i_req & r_pend & w_active & ~w_gap_end;
  end

  assign o_key_n = r_key_n;
  assign o_busy  = r_busy;
  assign o_drop  = r_drop;
endmodule

// File: rtl/key_press_gen.sv
// key_press_gen: N independent emulated push-button channels driven by single-cycle press requests.
module key_press_gen
  import key_gen_pkg::*;
#(
  parameter int N_KEYS         = 4,
  parameter int HOLD_CYCLES    = 1000000,
  parameter int GAP_CYCLES     = 500000,
  parameter int BOUNCE_CYCLES  = 5000,
  parameter int BOUNCE_TOGGLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] req,
  output logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] busy,
  output logic [N_KEYS-1:0] drop
);
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("key_press_gen: HOLD_CYCLES must be >= 1");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("key_press_gen: GAP_CYCLES must be >= 1");
  end
  if (BOUNCE_CYCLES < 1) begin : g_bad_bounce
    $error("key_press_gen: BOUNCE_CYCLES must be >= 1");
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    key_press_chan #(
      .HOLD_CYCLES   (HOLD_CYCLES),
      .GAP_CYCLES    (GAP_CYCLES),
      .BOUNCE_CYCLES (BOUNCE_CYCLES),
      .BOUNCE_TOGGLES(BOUNCE_TOGGLES)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_req  (req[i]),
      .o_key_n(key_n[i]),
      .o_busy (busy[i]),
      .o_drop (drop[i])
    );
  end
endmodule

// File: tb/tb_key_press_gen.sv
// tb_key_press_gen: directed checks of press timing, queueing, drop, bounce and async reset.
module tb_key_press_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = '0, req_b = '0;
  logic [3:0] key_n, busy, drop, key_b, busy_b, drop_b;
  int errors = 0, checks = 0;

  // Expected per-cycle values for cycles 11..30 (index = cycle - 11).
  logic [0:19] e_k0 = 20'b0000_1111_1111_1111_1111;
  logic [0:19] e_b0 = 20'b1111_1100_0000_0000_0000;
  logic [0:19] e_k1 = 20'b0000_1100_0011_1111_1111;
  logic [0:19] e_b1 = 20'b1111_1111_1111_0000_0000;
  logic [0:19] e_d1 = 20'b0001_0000_0000_0000_0000;
  logic [0:19] e_k3 = 20'b0000_1100_0011_0000_1111;
  logic [0:19] e_b3 = 20'b1111_1111_1111_1111_1100;
  logic [0:19] e_kb = 20'b0101_0000_1010_1111_1111;
  logic [0:19] e_bb = 20'b1111_1111_1111_1100_0000;

  always #5 clk = ~clk;

  key_press_gen #(.N_KEYS(4), .HOLD_CYCLES(4), .GAP_CYCLES(2), .BOUNCE_CYCLES(1), .BOUNCE_TOGGLES(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .key_n(key_n), .busy(busy), .drop(drop));

  key_press_gen #(.N_KEYS(4), .HOLD_CYCLES(4), .GAP_CYCLES(2), .BOUNCE_CYCLES(1), .BOUNCE_TOGGLES(2)) u_bnc (
    .clk(clk), .rst_n(rst_n), .req(req_b), .key_n(key_b), .busy(busy_b), .drop(drop_b));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'hF;
    req_b = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst key_n", key_n, 4'hF);
      chk("rst busy", busy, 4'h0);
      chk("rst drop", drop, 4'h0);
      chk("rst bnc key_n", key_b, 4'hF);
    end
    req   = '0;
    req_b = '0;
    rst_n = 1'b1;
    repeat (3) tick;
    for (int c = 10; c < 30; c++) begin
      int x;
      req = (c == 10) ? 4'b1011 : (c == 12) ? 4'b1010 : (c == 13) ? 4'b0010 : (c == 16) ? 4'b1000 : 4'b0000;
      req_b = (c == 10) ? 4'b0100 : 4'b0000;
      tick;
      x = c - 10;
      chk($sformatf("key_n c%0d", c + 1), key_n, {e_k3[x], 1'b1, e_k1[x], e_k0[x]});
      chk($sformatf("busy c%0d", c + 1), busy, {e_b3[x], 1'b0, e_b1[x], e_b0[x]});
      chk($sformatf("drop c%0d", c + 1), drop, {2'b00, e_d1[x], 1'b0});
      chk($sformatf("bnc key_n c%0d", c + 1), key_b, {1'b1, e_kb[x], 2'b11});
      chk($sformatf("bnc busy c%0d", c + 1), busy_b, {1'b0, e_bb[x], 2'b00});
    end
    req   = 4'hF;
    req_b = 4'hF;
    tick;
    chk("par key_n", key_n, 4'h0);
    chk("par busy", busy, 4'hF);
    chk("par bnc key_n", key_b, 4'h0);
    tick;
    req   = '0;
    req_b = '0;
    chk("par queue drop", drop, 4'h0);
    chk("par key_n hold", key_n, 4'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async key_n", key_n, 4'hF);
    chk("async busy", busy, 4'h0);
    chk("async bnc key_n", key_b, 4'hF);
    chk("async bnc busy", busy_b, 4'h0);
    tick;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick;
      chk($sformatf("stale key_n %0d", i), key_n, 4'hF);
      chk($sformatf("stale busy %0d", i), busy, 4'h0);
      chk($sformatf("stale bnc busy %0d", i), busy_b, 4'h0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
